// File: rtl/pipe_hazard_unit.sv
// Hazard-detection and forwarding controller for the in-order pipeline.
//
// A shift-register scoreboard tracks every in-flight instruction from EX (index 0)
// through WB (index DEPTH-1). From it the unit derives load-use stalls, EX-stage
// forwarding selects, flush bubbles and the HALT drain.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   id_valid                   decode stage holds a real instruction
//   id_src_a/b, id_src_a/b_en  decode source registers and their read enables
//   id_dst, id_wr_en           destination register and register-file write enable
//   id_is_load, id_is_halt     instruction class flags
//   flush                      discard the decode instruction (taken branch)
//   stall                      hold PC and IF/ID; a bubble goes into EX
//   fwd_sel_a/b                EX operand source: 0 = register file, k = entry k
//   halted                     HALT has reached WB (sticky)
//   stall_count                saturating count of load-use stall cycles
module pipe_hazard_unit #(
  parameter int unsigned REG_BITS = 3,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned SEL_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_src_a,
  input  logic [REG_BITS-1:0] id_src_b,
  input  logic                id_src_a_en,
  input  logic                id_src_b_en,
  input  logic [REG_BITS-1:0] id_dst,
  input  logic                id_wr_en,
  input  logic                id_is_load,
  input  logic                id_is_halt,
  input  logic                flush,
  output logic                stall,
  output logic [SEL_W-1:0]    fwd_sel_a,
  output logic [SEL_W-1:0]    fwd_sel_b,
  output logic                halted,
  output logic [CNT_W-1:0]    stall_count
);

  // Scoreboard, index 0 = EX ... DEPTH-1 = WB.
  logic [DEPTH-1:0]               valid_q;
  logic [DEPTH-1:0]               wr_q;
  logic [DEPTH-1:0]               load_q;
  logic [DEPTH-1:0]               halt_q;
  logic [DEPTH-1:0][REG_BITS-1:0] dst_q;

  // Source operands of the instruction currently in EX.
  logic [REG_BITS-1:0] ex_src_a_q;
  logic [REG_BITS-1:0] ex_src_b_q;
  logic                ex_en_a_q;
  logic                ex_en_b_q;

  logic             halt_lock_q;
  logic             halted_q;
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;

  logic hazard;
  logic accept;
  logic halted_now;

  // Load-use: a load still inside its latency window writes a register decode reads.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned j = 0; j < LOAD_LAT; j++) begin
      if (valid_q[j] && wr_q[j] && load_q[j]) begin
        if (id_src_a_en && (dst_q[j] == id_src_a)) hazard = 1'b1;
        if (id_src_b_en && (dst_q[j] == id_src_b)) hazard = 1'b1;
      end
    end
    hazard = hazard & id_valid & ~flush & ~halt_lock_q;
  end

  assign stall  = hazard | halt_lock_q;
  assign accept = id_valid & ~stall & ~flush & ~halt_lock_q;

  // Scan oldest to youngest so the lowest-index eligible writer wins.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
      if (valid_q[k] && wr_q[k] && (!load_q[k] || (k > LOAD_LAT))) begin
        if (ex_en_a_q && (dst_q[k] == ex_src_a_q)) fwd_sel_a = SEL_W'(k);
        if (ex_en_b_q && (dst_q[k] == ex_src_b_q)) fwd_sel_b = SEL_W'(k);
      end
    end
  end

  assign halted_now = halted_q | (valid_q[DEPTH-1] & halt_q[DEPTH-1]);
  assign halted     = halted_now;

  always_comb begin
    stall_count_d = stall_count_q;
    if (hazard && !(&stall_count_q)) stall_count_d = stall_count_q + CNT_W'(1);
  end
  assign stall_count = stall_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= '0;
      wr_q          <= '0;
      load_q        <= '0;
      halt_q        <= '0;
      dst_q         <= '0;
      ex_src_a_q    <= '0;
      ex_src_b_q    <= '0;
      ex_en_a_q     <= 1'b0;
      ex_en_b_q     <= 1'b0;
      halt_lock_q   <= 1'b0;
      halted_q      <= 1'b0;
      stall_count_q <= '0;
    end else begin
      // Payload fields shift in unconditionally; valid alone marks a bubble.
      valid_q       <= {valid_q[DEPTH-2:0], accept};
      wr_q          <= {wr_q[DEPTH-2:0], id_wr_en};
      load_q        <= {load_q[DEPTH-2:0], id_is_load};
      halt_q        <= {halt_q[DEPTH-2:0], id_is_halt};
      dst_q         <= {dst_q[DEPTH-2:0], id_dst};
      ex_src_a_q    <= id_src_a;
      ex_src_b_q    <= id_src_b;
      ex_en_a_q     <= accept & id_src_a_en;
      ex_en_b_q     <= accept & id_src_b_en;
      halt_lock_q   <= halt_lock_q | (accept & id_is_halt);
      halted_q      <= halted_now;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Randomised bench for pipe_hazard_unit. Two instances share one stimulus stream:
// DEPTH=3/LOAD_LAT=1 and DEPTH=4/LOAD_LAT=2 (narrow counter to reach saturation).
// The reference keeps, per instance, a history of what each past cycle accepted;
// the instruction at pipeline index j is the one accepted j+1 cycles ago.
module tb_pipe_hazard_unit;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       load;
    logic       halt;
    logic       en_a;
    logic       en_b;
    logic [2:0] dst;
    logic [2:0] src_a;
    logic [2:0] src_b;
  } instr_t;

  typedef struct packed {
    logic        hazard;
    logic        stall;
    logic        accept;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        halted;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_src_a_en, id_src_b_en, id_wr_en, id_is_load, id_is_halt, flush;
  logic [2:0] id_src_a, id_src_b, id_dst;

  logic        stall0, stall1, halted0, halted1;
  logic [1:0]  fa0, fb0, fa1, fb1;
  logic [15:0] cnt0;
  logic [2:0]  cnt1;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_BITS(3), .DEPTH(3), .LOAD_LAT(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_src_a_en(id_src_a_en), .id_src_b_en(id_src_b_en), .id_dst(id_dst), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_is_halt(id_is_halt), .flush(flush), .stall(stall0),
    .fwd_sel_a(fa0), .fwd_sel_b(fb0), .halted(halted0), .stall_count(cnt0)
  );

  pipe_hazard_unit #(.REG_BITS(3), .DEPTH(4), .LOAD_LAT(2), .CNT_W(3)) u_dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_src_a_en(id_src_a_en), .id_src_b_en(id_src_b_en), .id_dst(id_dst), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_is_halt(id_is_halt), .flush(flush), .stall(stall1),
    .fwd_sel_a(fa1), .fwd_sel_b(fb1), .halted(halted1), .stall_count(cnt1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state per instance.
  instr_t hist0[$];
  instr_t hist1[$];
  logic   lock_m[2];
  logic   halted_m[2];
  int     cnt_m[2];

  function automatic int depth_of(int m);   return (m == 0) ? 3 : 4; endfunction
  function automatic int lat_of(int m);     return (m == 0) ? 1 : 2; endfunction
  function automatic int cnt_max_of(int m); return (m == 0) ? 65535 : 7; endfunction

  function automatic instr_t ent(int m, int j);
    instr_t e = '0;
    if (m == 0) begin
      if (j < hist0.size()) e = hist0[j];
    end else begin
      if (j < hist1.size()) e = hist1[j];
    end
    return e;
  endfunction

  function automatic logic writes(instr_t e, logic [2:0] r);
    return e.valid && e.wr && (e.dst == r);
  endfunction

  function automatic exp_t eval(int m);
    exp_t   x = '0;
    instr_t e;
    instr_t ex = ent(m, 0);
    for (int j = 0; j < lat_of(m); j++) begin
      e = ent(m, j);
      if (e.load && ((id_src_a_en && writes(e, id_src_a)) || (id_src_b_en && writes(e, id_src_b))))
        x.hazard = 1'b1;
    end
    x.hazard = x.hazard && id_valid && !flush && !lock_m[m];
    x.stall  = x.hazard || lock_m[m];
    x.accept = id_valid && !x.stall && !flush && !lock_m[m];
    for (int k = 1; k < depth_of(m); k++) begin
      e = ent(m, k);
      if (!e.load || k > lat_of(m)) begin
        if (x.fa == 0 && ex.en_a && writes(e, ex.src_a)) x.fa = 2'(k);
        if (x.fb == 0 && ex.en_b && writes(e, ex.src_b)) x.fb = 2'(k);
      end
    end
    e = ent(m, depth_of(m) - 1);
    x.halted = halted_m[m] || (e.valid && e.halt);
    return x;
  endfunction

  task automatic update(int m, exp_t x);
    instr_t n = '0;
    if (reset) begin
      if (m == 0) hist0.delete(); else hist1.delete();
      lock_m[m] = 1'b0; halted_m[m] = 1'b0; cnt_m[m] = 0;
    end else begin
      halted_m[m] = x.halted;
      if (x.hazard && cnt_m[m] < cnt_max_of(m)) cnt_m[m]++;
      if (x.accept) begin
        n.valid = 1'b1; n.wr = id_wr_en; n.load = id_is_load; n.halt = id_is_halt;
        n.dst = id_dst; n.src_a = id_src_a; n.src_b = id_src_b;
        n.en_a = id_src_a_en; n.en_b = id_src_b_en;
      end
      if (m == 0) begin
        hist0.push_front(n);
        while (hist0.size() > depth_of(m)) void'(hist0.pop_back());
      end else begin
        hist1.push_front(n);
        while (hist1.size() > depth_of(m)) void'(hist1.pop_back());
      end
      lock_m[m] = lock_m[m] || (x.accept && id_is_halt);
    end
  endtask

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
  endtask

  // Inputs are changed only after negedge; outputs sampled mid-low-phase.
  task automatic step();
    exp_t e0, e1;
    #2;
    e0 = eval(0);
    e1 = eval(1);
    check("stall0", 32'(stall0), 32'(e0.stall));
    check("fwd_a0", 32'(fa0), 32'(e0.fa));
    check("fwd_b0", 32'(fb0), 32'(e0.fb));
    check("halted0", 32'(halted0), 32'(e0.halted));
    check("count0", 32'(cnt0), 32'(cnt_m[0]));
    check("stall1", 32'(stall1), 32'(e1.stall));
    check("fwd_a1", 32'(fa1), 32'(e1.fa));
    check("fwd_b1", 32'(fb1), 32'(e1.fb));
    check("halted1", 32'(halted1), 32'(e1.halted));
    check("count1", 32'(cnt1), 32'(cnt_m[1]));
    @(posedge clk);
    update(0, e0);
    update(1, e1);
    @(negedge clk);
  endtask

  task automatic drive(logic v, logic [2:0] sa, logic ea, logic [2:0] sb, logic eb,
                       logic [2:0] d, logic w, logic ld, logic h, logic fl, logic rs);
    id_valid = v; id_src_a = sa; id_src_a_en = ea; id_src_b = sb; id_src_b_en = eb;
    id_dst = d; id_wr_en = w; id_is_load = ld; id_is_halt = h; flush = fl; reset = rs;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      lock_m[m] = 1'b0; halted_m[m] = 1'b0; cnt_m[m] = 0;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    step(); step();
    // Back-to-back ALU forward, then gaps of one and two bubbles.
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
    drive(1, 1, 1, 2, 1, 4, 1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step(); step();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    drive(1, 1, 1, 2, 1, 4, 1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step(); step();
    // Load-use held in decode while stalled; then a flush over a pending hazard.
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0); step();
    drive(1, 2, 1, 3, 1, 5, 1, 0, 0, 0, 0); step(); step(); step();
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0); step();
    drive(1, 2, 1, 3, 1, 5, 1, 0, 0, 1, 0); step();
    drive(1, 3, 1, 3, 1, 6, 1, 0, 0, 0, 0); step(); step();
    // HALT drains, then reset clears everything.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    drive(1, 1, 1, 1, 1, 7, 1, 0, 0, 0, 0); step(); step(); step(); step(); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    // Random traffic on a small register set to provoke dense hazards.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, 3'($urandom % 4), ($urandom % 4) != 0,
            3'($urandom % 4), ($urandom % 4) != 0, 3'($urandom % 4), ($urandom % 4) != 0,
            ($urandom % 3) == 0, ($urandom % 30) == 0, ($urandom % 8) == 0,
            ($urandom % 40) == 0);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard-detection and forwarding controller for the in-order pipelined CPU.
- Tracks in-flight register writes from EX through WB in a shift-register scoreboard.
- Generates load-use stalls, EX-stage forwarding selects, flush bubbles and halt drain.
- Generalises the fixed 3-stage, 1-cycle-load hazard logic to arbitrary register-file size, post-ID depth and load latency; adds a stall performance counter.

Parameters:
- REG_BITS, 3, register index width.
- DEPTH, 3, in-flight stages after ID (index 0 = EX ... DEPTH-1 = WB); DEPTH >= 2.
- LOAD_LAT, 1, extra stages before load data is forwardable; 1 <= LOAD_LAT <= DEPTH-2.
- CNT_W, 16, stall counter width.
- SEL_W, $clog2(DEPTH), forward-select width.

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  decode stage holds a real instruction.
- id_src_a, id_src_b  in  REG_BITS  decode source registers.
- id_src_a_en, id_src_b_en  in  1  source is actually read.
- id_dst  in  REG_BITS  destination register.
- id_wr_en  in  1  instruction writes the register file.
- id_is_load  in  1  instruction is a memory load.
- id_is_halt  in  1  instruction is HALT.
- flush  in  1  discard decode instruction (taken branch).
- stall  out  1  hold PC and IF/ID; bubble into EX.
- fwd_sel_a, fwd_sel_b  out  SEL_W  EX operand source: 0 = register file; k = entry k.
- halted  out  1  HALT has reached WB.
- stall_count  out  CNT_W  saturating count of hazard stall cycles.

Behaviour:
- Scoreboard: DEPTH entries {valid, dst, wr, load, halt}, plus registered EX sources {src_a, en_a, src_b, en_b}.
- Every non-reset cycle, entry[j+1] <= entry[j]; entry[DEPTH-1] is dropped.
- entry[0] and the EX sources load the decode instruction if accept = id_valid & ~stall & ~flush & ~halt_lock. Otherwise they load a bubble (valid=0, en_a=en_b=0).
- match(j, s): entry[j].valid & entry[j].wr & dst == s.
- Load-use hazard: id_valid & ~flush & ~halt_lock & some enabled decode source s with match(j, s) & entry[j].load for some j < LOAD_LAT.
- stall = load-use hazard | halt_lock (combinational). flush masks the hazard term, so flush+hazard gives stall=0 and a bubble.
- Forwarding: fwd_sel_x = smallest k in 1..DEPTH-1 with en_x & match(k, src_x).
  - Load entries are eligible only when k > LOAD_LAT.
  - No eligible match gives 0.
  - The youngest (lowest-index) writer always wins.
  - Entry 0 is never a forward source.
- Writes older than entry DEPTH-1 are committed; the register file is write-first.
- Halt:
  - halt_lock sets on the cycle after a HALT is accepted and holds until reset.
  - While halt_lock is set, all decode instructions become bubbles.
  - halted rises the cycle the HALT entry occupies index DEPTH-1, and is sticky.
- stall_count increments by 1 on each cycle with a load-use hazard stall. halt_lock cycles are not counted. Saturates at all-ones.
- Reset (synchronous, priority over everything): all entries and EX sources invalid. stall=0, fwd_sel_a=fwd_sel_b=0, halted=0, halt_lock=0, stall_count=0.
- Reset asserted mid-stall or mid-halt clears everything the next edge. No hazard carries across reset.
- Simultaneous flush and id_is_halt: the HALT is discarded.

Test Plan:
- DEPTH=3, LOAD_LAT=1: ADD R1 then ADD R4,R1,R2 back-to-back gives fwd_sel_a=1 while the consumer is in EX. With one bubble between: fwd_sel_a=2. With two bubbles: 0. No stall in any case.
- LDR R2 then ADD R5,R2,R3: stall=1 for exactly one cycle, stall_count 0->1; then fwd_sel_a=2 in EX. Same with id_src_a_en=0: stall=0, fwd_sel_a=0.
- MOV R3 then ADD R3 then use R3: fwd_sel=1, not 2 (youngest wins). Both operands R3: fwd_sel_a=fwd_sel_b=1.
- Load-use pending with flush=1 the same cycle: stall=0, a bubble enters EX, stall_count unchanged, and the next cycle shows no hazard.
- HALT accepted at cycle t: stall=1 from t+1 onward and later instructions are bubbled. halted=1 at t+3 while the HALT occupies WB (index 2), and stays 1. Reset at t+5 clears halted and stall next edge.
- DEPTH=4, LOAD_LAT=2: load-use gives stall for 2 cycles, stall_count=2, then fwd_sel=3. stall_count preset near saturation stays at all-ones after further stalls.
